// File: rtl/shift_unloader_if.sv
// Handshake bundle for shift_unloader: the parallel load side and the serial bit stream.
// The master modport is the unloader itself; slave is the environment that drives it.
interface shift_unloader_if #(
    parameter int DW = 8
);
    logic          ld;
    logic [DW-1:0] data_in;
    logic          ready;
    logic          sout;
    logic          sout_valid;
    logic          sout_ready;
    logic          last;
    logic          done;

    modport master (
        input  ld, data_in, sout_ready,
        output ready, sout, sout_valid, last, done
    );

    modport slave (
        output ld, data_in, sout_ready,
        input  ready, sout, sout_valid, last, done
    );
endinterface

// File: rtl/shift_unloader.sv
// Parallel-to-serial unloader: captures a DW-bit word on ld and streams it out one bit
// per accepted transfer, flagging the final bit and pulsing done once the word has left.
//
// state   | meaning
// S_IDLE  | waiting for ld; ready=1, no valid bit
// S_SHIFT | presenting shreg output bit; shifts on sout_valid & sout_ready
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module shift_unloader #(
    parameter int DW        = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    shift_unloader_if.master  bus
);
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic ready;
    logic sout_valid;
    logic done;
    logic out_bit;
    logic [DW-1:0] shreg_shifted;

    // Output end is the MSB or LSB; the vacated position fills with zero.
    always_comb begin
        if (MSB_FIRST) begin
            out_bit       = shreg_q[DW-1];
            shreg_shifted = {shreg_q[DW-2:0], 1'b0};
        end else begin
            out_bit       = shreg_q[0];
            shreg_shifted = {1'b0, shreg_q[DW-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        ready      = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.ld) begin
                    shreg_d = bus.data_in;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sout_valid = 1'b1;
                if (bus.sout_ready) begin
                    shreg_d = shreg_shifted;
                    // Counter parks at its final value; it is cleared on the next load.
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ready      = ready;
    assign bus.sout_valid = sout_valid;
    assign bus.sout       = sout_valid & out_bit;
    assign bus.last       = sout_valid & (cnt_q == CNT_LAST);
    assign bus.done       = done;
endmodule

// File: doc/shift_unloader.md
SHIFT_UNLOADER -- requirements
Module: shift_unloader

Interface
REQ-001 SHALL have parameter DW, default 8, parallel word width; legal range DW >= 2.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = bit DW-1 sent first, 0 = bit 0 sent first.
REQ-003 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port ld, input, 1, request to capture data_in.
REQ-006 SHALL have port data_in, input, DW, parallel word to serialize.
REQ-007 SHALL have port ready, output, 1, high when a new ld will be accepted.
REQ-008 SHALL have port sout, output, 1, current serial bit.
REQ-009 SHALL have port sout_valid, output, 1, sout carries a valid bit.
REQ-010 SHALL have port sout_ready, input, 1, downstream accepts the bit this cycle.
REQ-011 SHALL have port last, output, 1, current valid bit is the final bit of the word.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the final bit is accepted.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT, DONE.
REQ-014 IDLE: ready=1, sout_valid=0; ld=1 captures data_in into the shift register, clears the bit counter, next state SHIFT.
REQ-015 ld SHALL be ignored in SHIFT and DONE (ready=0); the shift register SHALL NOT change on such ld.
REQ-016 SHIFT: sout_valid=1; sout = shreg[DW-1] if MSB_FIRST=1, else shreg[0].
REQ-017 Bit transfer SHALL occur only on a cycle with sout_valid=1 and sout_ready=1; then shreg shifts one position toward the output end, zero-filled, counter += 1.
REQ-018 With sout_ready=0 in SHIFT, sout, last, counter, shreg SHALL hold (stall without loss or duplication).
REQ-019 Counter width SHALL be clog2(DW); last = sout_valid AND (counter == DW-1).
REQ-020 Transfer with last=1 SHALL move the FSM to DONE; counter SHALL NOT wrap past DW-1.
REQ-021 DONE: done=1, ready=0, sout_valid=0 for exactly one cycle, then IDLE unconditionally.
REQ-022 Latency with sout_ready held 1: ld sampled at edge N -> first bit valid in cycle N+1, last bit in cycle N+DW, done in cycle N+DW+1, ready=1 again in cycle N+DW+2.
REQ-023 sout SHALL be 0 whenever sout_valid=0.
REQ-024 Exactly DW transfers SHALL occur per accepted ld, and done SHALL pulse exactly once per completed word.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, shreg=0, counter=0, regardless of ld or state.
REQ-026 During and after reset: ready=1, sout=0, sout_valid=0, last=0, done=0.
REQ-027 rst SHALL take priority over ld in the same cycle; that ld is dropped.
REQ-028 Reset during SHIFT or DONE SHALL abort the word with no done pulse and no further valid bits.

Verification
REQ-029 DW=8, MSB_FIRST=1, data_in=8'hA5, ld one cycle, sout_ready=1 -> sout sequence 1,0,1,0,0,1,0,1 over 8 cycles, last only on 8th, done next cycle, ready after.
REQ-030 DW=8, MSB_FIRST=0, data_in=8'h01 -> sout sequence 1,0,0,0,0,0,0,0; last on 8th bit.
REQ-031 8'hC3 with sout_ready toggled 1,0,0,1,... -> bits unchanged while stalled; received word equals 8'hC3; exactly 8 transfers; one done.
REQ-032 ld=1 with data_in=8'hFF asserted during SHIFT of 8'h0F -> ignored; output word remains 8'h0F; no second word.
REQ-033 rst=1 after 3 transferred bits -> next cycle sout_valid=0, ready=1, no done; new ld of 8'h5A then serializes cleanly.
REQ-034 Back-to-back: ld held 1 continuously with data 8'h11 then 8'h22 -> second word captured in the first cycle ready=1 after done; outputs 8'h11 then 8'h22 with one idle and one done cycle between.
